// File: rtl/spy_readout_if.sv
// RAM read port and output stream of the spy-buffer readout engine.
interface spy_readout_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              rden;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output rden, raddr, out_data, out_valid, out_last,
                  input  rdata, out_ready);
  modport slave  (input  rden, raddr, out_data, out_valid, out_last,
                  output rdata, out_ready);
endinterface

// File: rtl/spy_readout.sv
// Streams a header word plus the whole locked spy RAM in address order, then
// pulses rearm so the capture controller can start over.
module spy_readout #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          capture_done,
  input  logic          rd_req,
  spy_readout_if.master bus,
  output logic          busy,
  output logic          rearm,
  output logic          req_err
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, HEADER, STREAM, REARM} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-5:0]   seq_q, seq_d;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]   pop_cnt_q, pop_cnt_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [RD_LAT:1]     vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                req_err_q, req_err_d;
  logic [DATA_W-1:0]   fifo_mem [DEPTH];

  logic [CW-1:0]       inflight;
  logic [CW:0]         claimed;
  logic                fifo_vld, issue, push, pop, last_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_req && capture_done) state_d = HEADER;
      HEADER:  if (bus.out_ready) state_d = STREAM;
      STREAM:  if (pop && last_word) state_d = REARM;
      REARM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    busy          = (state_q != IDLE);
    rearm         = (state_q == REARM);
    case (state_q)
      HEADER: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {4'hA, seq_q};
      end
      STREAM: begin
        bus.out_valid = fifo_vld;
        bus.out_last  = last_word;
        if (fifo_vld) bus.out_data = fifo_mem[rd_ptr_q];
      end
      default: ;
    endcase
  end

  // Every issued read reserves a FIFO slot up front, so returning data always fits.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LAT; i++) inflight = inflight + CW'(vld_pipe_q[i]);
    claimed   = {1'b0, cnt_q} + {1'b0, inflight};
    fifo_vld  = (cnt_q != '0);
    issue     = (state_q == HEADER || state_q == STREAM) && !issue_cnt_q[ADDR_W]
                && (claimed < (CW+1)'(DEPTH));
    push      = vld_pipe_q[RD_LAT];
    pop       = (state_q == STREAM) && fifo_vld && bus.out_ready;
    last_word = (state_q == STREAM) && fifo_vld && (&pop_cnt_q);

    issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(issue);
    pop_cnt_d   = pop_cnt_q + ADDR_W'(pop);
    if (state_q == IDLE) begin
      issue_cnt_d = '0;
      pop_cnt_d   = '0;
    end
    raddr_d   = issue ? issue_cnt_q[ADDR_W-1:0] : raddr_q;
    seq_d     = seq_q + (DATA_W-4)'(state_q == REARM);
    req_err_d = (state_q == IDLE) && rd_req && !capture_done;

    vld_pipe_d[1] = issue;
    for (int i = 2; i <= RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign bus.rden  = issue;
  assign bus.raddr = raddr_d;
  assign req_err   = req_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      raddr_q     <= '0;
      vld_pipe_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      req_err_q   <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      raddr_q     <= raddr_d;
      vld_pipe_q  <= vld_pipe_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      req_err_q   <= req_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.rdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && cnt_q == CW'(DEPTH)));
endmodule
